// File: rtl/dieu_khien_bom_pkg.sv
// Purpose: shared state encoding, fault codes and sizing helpers for the pump controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dieu_khien_bom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_STALL    = 2'd1;
  localparam logic [1:0] FC_CONFLICT = 2'd2;

  // Largest of three cycle counts; the timers and stall counter share one width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold maxv, never less than one.
  function automatic int cnt_width(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/dieu_khien_bom_hen_gio.sv
// Purpose: loadable down-counter with a zero flag, used as the pump on/off timer.
// Latency: load takes effect on the next rising edge; zero is a decode of the count.
// Backpressure: none; load wins over decrement, decrement stops at zero.
module hen_gio #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: load has priority, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dieu_khien_bom.sv
// Purpose: pump control FSM with hysteresis, minimum on/off times, stall and sensor-conflict faults.
// Latency: inputs sampled at edge N drive state and p visible after edge N (p decodes the next state).
// Backpressure: none; fault_clr is a single-cycle request, start requests during lockout are dropped.
module dieu_khien_bom
  import dieu_khien_bom_pkg::*;
#(
  parameter int HI_TH     = 200,
  parameter int LO_TH     = 50,
  parameter int MIN_ON    = 16,
  parameter int MIN_OFF   = 16,
  parameter int STALL_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] level,
  input  logic       high,
  input  logic       low,
  input  logic       fault_clr,
  output logic       p,
  output logic [1:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int TW = cnt_width(max3(MIN_ON, MIN_OFF, STALL_CYC));

  localparam logic [TW-1:0] ON_V    = TW'(MIN_ON);
  localparam logic [TW-1:0] OFF_V   = TW'(MIN_OFF);
  localparam logic [TW-1:0] STALL_V = TW'(STALL_CYC);
  localparam logic [TW-1:0] ONE_V   = TW'(1);
  localparam logic [7:0]    HI_V    = 8'(HI_TH);
  localparam logic [7:0]    LO_V    = 8'(LO_TH);

  state_t        state_q, state_d;
  logic          p_q;
  logic          fault_q;
  logic [1:0]    code_q, code_d;
  logic [7:0]    lvl_q;
  logic [TW-1:0] stall_q, stall_d;
  logic          stall_clr;
  logic          stall_hit;
  logic          conflict;
  logic          start_req;
  logic          stop_req;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_dec;
  logic [TW-1:0] tmr_count;
  logic          tmr_zero;
  logic          tmr_done;

  assign conflict  = high && low;
  assign start_req = (level >= HI_V) || high;
  assign stop_req  = (level <= LO_V) || low;

  // The timer is "done" on the edge where it would reach zero, so RUN and LOCK
  // each last exactly the loaded number of cycles (a load of 0 acts like 1 cycle).
  assign tmr_done = tmr_zero || (tmr_count == ONE_V);
  assign tmr_dec  = (state_q == ST_RUN) || (state_q == ST_LOCK);

  hen_gio #(
    .W(TW)
  ) u_hen_gio (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Stall counter candidate: a drop in level (including 255 -> 0 wrap) clears it,
  // anything else counts up and saturates.
  always_comb begin
    stall_d = stall_q;
    if (level < lvl_q) begin
      stall_d = '0;
    end else if (stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign stall_hit = (stall_d >= STALL_V);

  // Next-state logic; faults outrank the low override, which outranks the normal stop.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    tmr_load  = 1'b0;
    tmr_val   = ON_V;
    stall_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (conflict) begin
          state_d = ST_FAULT;
          code_d  = FC_CONFLICT;
        end else if (start_req) begin
          state_d   = ST_RUN;
          tmr_load  = 1'b1;
          tmr_val   = ON_V;
          stall_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (conflict) begin
          state_d = ST_FAULT;
          code_d  = FC_CONFLICT;
        end else if (low) begin
          state_d  = ST_LOCK;
          tmr_load = 1'b1;
          tmr_val  = OFF_V;
        end else if (stall_hit) begin
          state_d = ST_FAULT;
          code_d  = FC_STALL;
        end else if (tmr_done && stop_req) begin
          state_d  = ST_LOCK;
          tmr_load = 1'b1;
          tmr_val  = OFF_V;
        end
      end
      ST_LOCK: begin
        if (conflict) begin
          state_d = ST_FAULT;
          code_d  = FC_CONFLICT;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !conflict) begin
          state_d  = ST_LOCK;
          code_d   = FC_NONE;
          tmr_load = 1'b1;
          tmr_val  = OFF_V;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = FC_NONE;
      end
    endcase
  end

  // State, registered outputs and the previous-level copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= (state_d == ST_RUN);
      fault_q <= (state_d == ST_FAULT);
      code_q  <= code_d;
      lvl_q   <= level;
    end
  end

  // Stall counter only advances while running; cleared on every start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_clr) begin
      stall_q <= '0;
    end else if (state_q == ST_RUN) begin
      stall_q <= stall_d;
    end
  end

  assign p          = p_q;
  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_dieu_khien_bom.sv
// Purpose: directed, table-driven bench for the pump controller.
// Latency: checks one cycle per applied vector, sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_dieu_khien_bom;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] level;
  logic       high;
  logic       low;
  logic       fault_clr;
  logic       p;
  logic [1:0] state;
  logic       fault;
  logic [1:0] fault_code;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] level;
    logic       high;
    logic       low;
    logic       clr;
    logic       exp_p;
    logic [1:0] exp_state;
    logic       exp_fault;
    logic [1:0] exp_code;
  } vec_t;

  vec_t tbl[$];

  dieu_khien_bom dut (
    .clk        (clk),
    .rst        (rst),
    .level      (level),
    .high       (high),
    .low        (low),
    .fault_clr  (fault_clr),
    .p          (p),
    .state      (state),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ep, input logic [1:0] es,
                           input logic ef, input logic [1:0] ec);
    check({tag, ".p"}, int'(p), int'(ep));
    check({tag, ".state"}, int'(state), int'(es));
    check({tag, ".fault"}, int'(fault), int'(ef));
    check({tag, ".code"}, int'(fault_code), int'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] lv, input logic h, input logic l, input logic c,
                     input logic ep, input logic [1:0] es, input logic ef, input logic [1:0] ec);
    vec_t v;
    v.level = lv; v.high = h; v.low = l; v.clr = c;
    v.exp_p = ep; v.exp_state = es; v.exp_fault = ef; v.exp_code = ec;
    tbl.push_back(v);
  endtask

  // Fifteen cycles still in LOCK, then IDLE on the sixteenth.
  task automatic add_lock_wait(input logic [7:0] lv);
    for (int i = 0; i < 15; i++) add(lv, 1'b0, 1'b0, 1'b0, 1'b0, S_LOCK, 1'b0, 2'd0);
    add(lv, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, 2'd0);
  endtask

  initial begin
    // Conflict table, starting from IDLE with level 0.
    add(8'd0, 1, 1, 1, 0, S_FAULT, 1, 2'd2);  // new fault beats same-cycle clear
    add(8'd0, 1, 1, 1, 0, S_FAULT, 1, 2'd2);  // clear ignored while conflict holds
    add(8'd0, 1, 0, 0, 0, S_FAULT, 1, 2'd2);  // latched without a clear
    add(8'd0, 1, 0, 1, 0, S_LOCK,  0, 2'd0);  // clear accepted once low drops
    add(8'd0, 1, 1, 0, 0, S_FAULT, 1, 2'd2);  // conflict detected in LOCK
    add(8'd0, 0, 0, 1, 0, S_LOCK,  0, 2'd0);
    add_lock_wait(8'd0);
    add(8'd0, 1, 0, 0, 1, S_RUN,   0, 2'd0);  // high float alone starts pump
    add(8'd0, 0, 0, 0, 1, S_RUN,   0, 2'd0);  // low level but on-timer still running
    add(8'd0, 1, 1, 0, 0, S_FAULT, 1, 2'd2);  // conflict beats low override in RUN
    add(8'd0, 0, 0, 1, 0, S_LOCK,  0, 2'd0);
    add_lock_wait(8'd0);

    rst = 1'b1; level = 8'd0; high = 1'b0; low = 1'b0; fault_clr = 1'b0;
    step();
    check_all("reset_held", 0, S_IDLE, 0, 2'd0);
    rst = 1'b0;
    check_all("reset_rel", 0, S_IDLE, 0, 2'd0);

    // Start on level threshold.
    level = 8'd210;
    step();
    check_all("start", 1, S_RUN, 0, 2'd0);

    // Drain from 209 down to 50; stop only when 50 is sampled.
    for (int lv = 209; lv >= 50; lv--) begin
      level = 8'(lv);
      step();
      check($sformatf("drain%0d.p", lv), int'(p), (lv == 50) ? 0 : 1);
      if (lv == 50) check("drain50.state", int'(state), int'(S_LOCK));
    end

    // Hold 210 through lockout: ignored for exactly 16 cycles, then restart.
    level = 8'd210;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("lock%0d.state", i), int'(state), int'(S_LOCK));
      check($sformatf("lock%0d.p", i), int'(p), 0);
    end
    step();
    check_all("lock_end", 0, S_IDLE, 0, 2'd0);
    step();
    check_all("restart", 1, S_RUN, 0, 2'd0);

    // Low override at RUN cycle 3, well inside MIN_ON.
    step();
    check_all("run1", 1, S_RUN, 0, 2'd0);
    step();
    check_all("run2", 1, S_RUN, 0, 2'd0);
    low = 1'b1;
    step();
    check_all("low_ovr", 0, S_LOCK, 0, 2'd0);
    low = 1'b0; level = 8'd100;
    for (int i = 1; i <= 15; i++) step();
    check_all("ovr_lock15", 0, S_LOCK, 0, 2'd0);
    step();
    check_all("ovr_idle", 0, S_IDLE, 0, 2'd0);
    step();
    check_all("idle_mid", 0, S_IDLE, 0, 2'd0);

    // Stall: constant 220 while running faults 64 cycles after start.
    level = 8'd220;
    step();
    check_all("stall_start", 1, S_RUN, 0, 2'd0);
    for (int k = 1; k <= 63; k++) begin
      step();
      check($sformatf("stall%0d.fault", k), int'(fault), 0);
      check($sformatf("stall%0d.p", k), int'(p), 1);
    end
    step();
    check_all("stall_hit", 0, S_FAULT, 1, 2'd1);
    step();
    check_all("stall_hold", 0, S_FAULT, 1, 2'd1);
    level = 8'd0; fault_clr = 1'b1;
    step();
    check_all("stall_clr", 0, S_LOCK, 0, 2'd0);
    fault_clr = 1'b0;
    for (int i = 1; i <= 15; i++) step();
    step();
    check_all("stall_idle", 0, S_IDLE, 0, 2'd0);

    // Table-driven conflict and priority sequences.
    foreach (tbl[i]) begin
      level = tbl[i].level; high = tbl[i].high; low = tbl[i].low; fault_clr = tbl[i].clr;
      step();
      check_all($sformatf("tbl%0d", i), tbl[i].exp_p, tbl[i].exp_state,
                tbl[i].exp_fault, tbl[i].exp_code);
    end
    high = 1'b0; low = 1'b0; fault_clr = 1'b0;

    // Asynchronous reset in the middle of RUN.
    level = 8'd210;
    step();
    check_all("pre_rst", 1, S_RUN, 0, 2'd0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 0, S_IDLE, 0, 2'd0);
    level = 8'd0;
    step();
    rst = 1'b0;
    check_all("post_rst", 0, S_IDLE, 0, 2'd0);
    step();
    check_all("post_rst_idle", 0, S_IDLE, 0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dieu_khien_bom.md
# dieu_khien_bom

Pump control FSM driving the pump-enable line `p` that the tank level up/down counter consumes. It reads the 8-bit level count and the high/low float switches, and runs the pump, which drains the tank, with hysteresis and minimum on/off times. It also detects a stalled pump or inconsistent sensors. It sits beside the level counter in the pump system top level: the counter produces `level`, and this block returns `p`.

## Interface
- `HI_TH`, 200: level at or above which the pump starts.
- `LO_TH`, 50: level at or below which the pump stops; must be < `HI_TH`.
- `MIN_ON`, 16: minimum pump-on cycles.
- `MIN_OFF`, 16: minimum pump-off lockout cycles.
- `STALL_CYC`, 64: cycles without a level decrease while running before a stall fault.

- `clk` in 1: system clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `level` in 8: unsigned tank level from the level counter.
- `high` in 1: tank-full float switch, active-high.
- `low` in 1: tank-empty float switch, active-high.
- `fault_clr` in 1: single-cycle fault acknowledge.
- `p` out 1: pump enable, registered.
- `state` out 2: current FSM state (encoding in package).
- `fault` out 1: fault latched.
- `fault_code` out 2: 0 none, 1 stall, 2 sensor conflict.

## Operation
- States: IDLE (pump off, may start), RUN (pump on), LOCK (pump off, lockout timing), FAULT (pump off, latched).
- IDLE -> RUN when `level >= HI_TH` or `high`. Load the on-timer with `MIN_ON` and clear the stall counter.
- RUN -> LOCK when the on-timer has expired and (`level <= LO_TH` or `low`).
- RUN -> LOCK immediately when `low` is asserted, even before `MIN_ON` expires. This is the dry-run safety override. Load the off-timer with `MIN_OFF` on entry.
- LOCK -> IDLE when the off-timer reaches 0. Start requests during LOCK are ignored, not queued.
- Stall detection runs in RUN only:
  - Keep a registered copy of `level`.
  - If `level` < the previous copy, clear the stall counter; otherwise increment it, saturating.
  - When the counter reaches `STALL_CYC`: go to FAULT with `fault_code` = 1.
- Sensor conflict: `high && low` in any non-FAULT state sends the FSM to FAULT with `fault_code` = 2. Conflict takes priority over stall, and both take priority over normal transitions.
- FAULT -> LOCK on `fault_clr` only if the fault condition is gone (no `high && low`). On that transition `fault` and `fault_code` clear and the off-timer loads `MIN_OFF`. A `fault_clr` while the conflict persists is ignored.
- `level` wrap-around, e.g. 255 -> 0 from the counter, is treated as a decrease for stall purposes. No other arithmetic is done on `level`.
- Timers are down-counters sized to hold the largest of `MIN_ON`, `MIN_OFF` and `STALL_CYC`. Parameters of 0 mean "expired immediately".

## Timing
- Reset values: state IDLE, `p` 0, `fault` 0, `fault_code` 0, all timers and the stall counter 0, level copy 0.
- Inputs are sampled at edge N. The resulting state and `p` are visible after edge N. `p` is a registered decode of the next state, with one cycle of latency from the condition.
- RUN lasts at least `MIN_ON` cycles unless `low` or a fault intervenes.
- LOCK lasts exactly `MIN_OFF` cycles.
- A stall fault asserts `STALL_CYC` cycles after the last observed decrease.
- Reset asserted mid-RUN drops `p` asynchronously to 0 and clears any fault.
- Simultaneous events in RUN, in priority order: conflict, then `low` override, then stall, then normal stop.
- `fault_clr` in the same cycle that a new fault is detected: the fault wins.

## Structure
- A shared package holds the state encoding (IDLE=0, RUN=1, LOCK=2, FAULT=3) and the fault code constants.
- One sub-module, `hen_gio`, implements the loadable down-counter with a `zero` flag. It is instantiated for the on/off timer. The stall counter stays inline because it needs saturating up-count behaviour.

## Test plan
- After reset, drive `level`=210: `p` rises 1 cycle later, `state`=RUN.
- Decrement `level` by 1 per cycle from 210 to 50: `p` stays high until `level`=50 is sampled and the on-timer has expired. The block then goes to LOCK, and returns to IDLE after 16 cycles with `level`=210 held. Once IDLE is reached, the start condition is re-evaluated and `p` rises again one cycle later.
- In RUN at cycle 3, assert `low`: `p` drops next cycle despite `MIN_ON`=16, and the block enters LOCK.
- In RUN, hold `level`=220 constant: `fault`=1, `fault_code`=1 and `p`=0 after 64 cycles. A `fault_clr` then moves the block to LOCK.
- Assert `high` and `low` together in IDLE: `fault_code`=2. `fault_clr` while both remain high has no effect. After `low` drops, `fault_clr` moves the block to LOCK.
- Assert `rst` mid-RUN: `p`=0 without waiting for a clock edge. After release, the block is IDLE with all outputs at their reset values.
